// File: rtl/wb_commit_tracker.sv
// wb_commit_tracker
// Passive commit tracker for the DV harness. Pairs load issues seen in EX with
// their later LSU write-backs, merges them with ALU write-backs, and emits one
// ordered commit record per register write on a valid/ready stream.
//
// Ports
//   clk, rst_n                      core clock, async active-low reset
//   ex_valid, pc_ex                 EX completion strobe and its PC
//   regfile_we_ex, regfile_waddr_ex load issue in EX and its destination
//   regfile_alu_we_fw/_waddr_fw/_wdata_fw   ALU/MUL write-back
//   regfile_we_wb, regfile_waddr_fw_wb_o, regfile_wdata   LSU write-back
//   rec_valid/rec_ready, rec_pc/rd/data/is_load           record stream
//   commit_count                    records pushed since reset (wraps)
//   drop_count                      records dropped (saturates)
//   err_overflow/err_orphan_wb/err_rd_mismatch            sticky error flags
module wb_commit_tracker #(
  parameter int LQ_DEPTH = 4,
  parameter int OQ_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] pc_ex,
  input  logic        regfile_we_ex,
  input  logic [5:0]  regfile_waddr_ex,
  input  logic        regfile_alu_we_fw,
  input  logic [5:0]  regfile_alu_waddr_fw,
  input  logic [31:0] regfile_alu_wdata_fw,
  input  logic        regfile_we_wb,
  input  logic [5:0]  regfile_waddr_fw_wb_o,
  input  logic [31:0] regfile_wdata,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [31:0] rec_pc,
  output logic [5:0]  rec_rd,
  output logic [31:0] rec_data,
  output logic        rec_is_load,
  output logic [31:0] commit_count,
  output logic [15:0] drop_count,
  output logic        err_overflow,
  output logic        err_orphan_wb,
  output logic        err_rd_mismatch
);

  localparam int LAW = $clog2(LQ_DEPTH);
  localparam int OAW = $clog2(OQ_DEPTH);
  localparam logic [OAW+1:0] OQ_CAP = (OAW+2)'(OQ_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  rd;
    logic [31:0] data;
    logic        is_load;
  } rec_t;

  // ---------------- load queue ----------------
  logic [31:0]  lq_pc [LQ_DEPTH];
  logic [5:0]   lq_rd [LQ_DEPTH];
  logic [LAW:0] lq_wptr, lq_rptr;
  logic         lq_empty, lq_full, lq_push_req, lq_push, lq_pop, lq_drop;
  logic [31:0]  lq_head_pc;
  logic [5:0]   lq_head_rd;

  assign lq_empty    = (lq_wptr == lq_rptr);
  assign lq_full     = (lq_wptr[LAW] != lq_rptr[LAW]) &&
                       (lq_wptr[LAW-1:0] == lq_rptr[LAW-1:0]);
  assign lq_head_pc  = lq_pc[lq_rptr[LAW-1:0]];
  assign lq_head_rd  = lq_rd[lq_rptr[LAW-1:0]];
  assign lq_push_req = ex_valid && regfile_we_ex;
  // Emptiness is judged on the current state, so a same-cycle push can never
  // satisfy this cycle's write-back.
  assign lq_pop      = regfile_we_wb && !lq_empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign lq_push     = lq_push_req && (!lq_full || lq_pop);
  assign lq_drop     = lq_push_req && !lq_push;

  // NOTE: storage arrays carry no reset; the pointers alone say which entries
  // are live, so resetting the data would only cost flops.
  always_ff @(posedge clk) begin
    if (lq_push) begin
      lq_pc[lq_wptr[LAW-1:0]] <= pc_ex;
      lq_rd[lq_wptr[LAW-1:0]] <= regfile_waddr_ex;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lq_wptr <= '0;
      lq_rptr <= '0;
    end else begin
      if (lq_push) lq_wptr <= lq_wptr + 1'b1;
      if (lq_pop)  lq_rptr <= lq_rptr + 1'b1;
    end
  end

  // ---------------- record formation and output queue ----------------
  rec_t         oq_mem [OQ_DEPTH];
  logic [OAW:0] oq_wptr, oq_rptr, oq_count;
  logic [OAW+1:0] oq_free;
  logic         oq_pop;
  logic         lsu_v, alu_v, lsu_push, alu_push;
  rec_t         lsu_rec, alu_rec, first_rec;
  logic [1:0]   n_push, n_drop;
  logic [OAW-1:0] slot0, slot1;
  rec_t         head;

  assign lsu_v    = regfile_we_wb;
  assign alu_v    = regfile_alu_we_fw && ex_valid;
  assign oq_pop   = rec_valid && rec_ready;
  assign oq_count = oq_wptr - oq_rptr;
  // Space is measured after this cycle's pop, so a full queue being drained
  // can still take one record.
  assign oq_free  = OQ_CAP - {1'b0, oq_count} + (OAW+2)'(oq_pop);
  assign slot0    = oq_wptr[OAW-1:0];
  assign slot1    = oq_wptr[OAW-1:0] + 1'b1;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a value held and no latch is inferred.
  always_comb begin
    lsu_rec   = '0;
    alu_rec   = '0;
    lsu_push  = 1'b0;
    alu_push  = 1'b0;
    first_rec = '0;

    lsu_rec.pc      = lq_empty ? 32'h0 : lq_head_pc;
    lsu_rec.rd      = regfile_waddr_fw_wb_o;
    lsu_rec.data    = regfile_wdata;
    lsu_rec.is_load = 1'b1;

    alu_rec.pc      = pc_ex;
    alu_rec.rd      = regfile_alu_waddr_fw;
    alu_rec.data    = regfile_alu_wdata_fw;
    alu_rec.is_load = 1'b0;

    // The LSU record is the older instruction and claims space first.
    lsu_push = lsu_v && (oq_free != '0);
    if (lsu_v) alu_push = alu_v && (oq_free[OAW+1:1] != '0);
    else       alu_push = alu_v && (oq_free != '0);

    first_rec = lsu_push ? lsu_rec : alu_rec;
  end

  assign n_push = 2'(lsu_push) + 2'(alu_push);
  assign n_drop = 2'(lsu_v && !lsu_push) + 2'(alu_v && !alu_push) + 2'(lq_drop);

  always_ff @(posedge clk) begin
    if (n_push != 2'd0) oq_mem[slot0] <= first_rec;
    if (n_push == 2'd2) oq_mem[slot1] <= alu_rec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oq_wptr <= '0;
      oq_rptr <= '0;
    end else begin
      oq_wptr <= oq_wptr + (OAW+1)'(n_push);
      if (oq_pop) oq_rptr <= oq_rptr + 1'b1;
    end
  end

  // Head is read straight from registered storage; outputs are masked to 0
  // while empty so reset (and mid-stream reset) clears them asynchronously.
  assign head        = oq_mem[oq_rptr[OAW-1:0]];
  assign rec_valid   = (oq_wptr != oq_rptr);
  assign rec_pc      = rec_valid ? head.pc      : 32'h0;
  assign rec_rd      = rec_valid ? head.rd      : 6'h0;
  assign rec_data    = rec_valid ? head.data    : 32'h0;
  assign rec_is_load = rec_valid && head.is_load;

  // ---------------- counters and sticky errors ----------------
  logic [16:0] drop_sum;
  assign drop_sum = {1'b0, drop_count} + 17'(n_drop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_count    <= '0;
      drop_count      <= '0;
      err_overflow    <= 1'b0;
      err_orphan_wb   <= 1'b0;
      err_rd_mismatch <= 1'b0;
    end else begin
      commit_count <= commit_count + 32'(n_push);
      drop_count   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (n_drop != 2'd0)                err_overflow    <= 1'b1;
      if (regfile_we_wb && lq_empty)     err_orphan_wb   <= 1'b1;
      if (lq_pop && (regfile_waddr_fw_wb_o != lq_head_rd))
                                         err_rd_mismatch <= 1'b1;
    end
  end

endmodule
